// File: rtl/dac_spi_pkg.sv
// ============================================================================
// dac_spi_pkg
// Shared definitions for the DAC configuration SPI link: the receiver FSM
// state encoding, the synchronizer depth used on every asynchronous serial
// input, and the default frame/timeout sizes.
// ============================================================================
package dac_spi_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        ABORT = 2'd3
    } state_t;

    // Number of flops between an asynchronous pin and the first usable copy
    localparam int SYNC_DEPTH = 2;

    // Default sizing of the receiver
    localparam int SHIFT_REG_WIDTH_MAX_DEF = 16;
    localparam int TIMEOUT_CYCLES_DEF      = 1000;

endpackage

// File: rtl/dac_spi_s2p_receiver_if.sv
// ============================================================================
// dac_spi_s2p_receiver_if
// Bundles the serial SPI pins, the programmed frame width and the receiver's
// parallel results into one interface.
//   master : drives Serial_clk/Serial_data/Serial_data_en and S2P_Width,
//            observes S2P_DATA_OUT/S2P_Valid/S2P_Err/S2P_BUSY
//   slave  : the receiver side (directions reversed)
// ============================================================================
interface dac_spi_s2p_receiver_if
    import dac_spi_pkg::*;
#(
    parameter int SHIFT_REG_WIDTH_MAX = SHIFT_REG_WIDTH_MAX_DEF
);
    localparam int WIDTH_W = $clog2(SHIFT_REG_WIDTH_MAX + 1);

    logic [WIDTH_W-1:0]             S2P_Width;
    logic                           Serial_clk;
    logic                           Serial_data;
    logic                           Serial_data_en;
    logic [SHIFT_REG_WIDTH_MAX-1:0] S2P_DATA_OUT;
    logic                           S2P_Valid;
    logic                           S2P_Err;
    logic                           S2P_BUSY;

    modport master (
        output S2P_Width, Serial_clk, Serial_data, Serial_data_en,
        input  S2P_DATA_OUT, S2P_Valid, S2P_Err, S2P_BUSY
    );

    modport slave (
        input  S2P_Width, Serial_clk, Serial_data, Serial_data_en,
        output S2P_DATA_OUT, S2P_Valid, S2P_Err, S2P_BUSY
    );

endinterface

// File: rtl/sync_edge_det.sv
// ============================================================================
// sync_edge_det
// Brings one asynchronous input into the clk domain through SYNC_DEPTH flops,
// then keeps one more flop of history to produce single-cycle rise/fall pulses.
// RESET_VAL sets every flop of the chain, so an input already at that level
// when reset is released produces no edge.
//   clk, rst : system clock, asynchronous active-high reset
//   i_async  : asynchronous input
//   o_sync   : synchronized level
//   o_rise   : one-cycle pulse on a synchronized 0->1 transition
//   o_fall   : one-cycle pulse on a synchronized 1->0 transition
// ============================================================================
module sync_edge_det
    import dac_spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  r_prev;

    // Synchronizer chain followed by a history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_DEPTH{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], i_async};
            r_prev <= r_sync[SYNC_DEPTH-1];
        end
    end

    assign o_sync = r_sync[SYNC_DEPTH-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/dac_spi_s2p_receiver.sv
// ============================================================================
// dac_spi_s2p_receiver
// Oversampling SPI serial-to-parallel receiver. Assembles MSB-first frames of
// S2P_Width bits and reports each one as a valid word or as an error
// (wrong length, overflow, or Serial_clk stalled mid-frame).
//   clk  : system clock (120 MHz)
//   rst  : asynchronous active-high reset
//   s2p  : slave side of dac_spi_s2p_receiver_if
//          in : S2P_Width, Serial_clk, Serial_data, Serial_data_en
//          out: S2P_DATA_OUT, S2P_Valid, S2P_Err, S2P_BUSY
// ============================================================================
module dac_spi_s2p_receiver
    import dac_spi_pkg::*;
#(
    parameter int SHIFT_REG_WIDTH_MAX = SHIFT_REG_WIDTH_MAX_DEF,
    parameter int TIMEOUT_CYCLES      = TIMEOUT_CYCLES_DEF
) (
    input logic                   clk,
    input logic                   rst,
    dac_spi_s2p_receiver_if.slave s2p
);

    localparam int WIDTH_W = $clog2(SHIFT_REG_WIDTH_MAX + 1);
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [WIDTH_W-1:0] MAX_BITS = WIDTH_W'(SHIFT_REG_WIDTH_MAX);
    localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                         r_state;
    state_t                         w_stateNext;
    logic [SHIFT_REG_WIDTH_MAX-1:0] r_shift;
    logic [WIDTH_W-1:0]             r_bitCnt;
    logic                           r_overflow;
    logic [CNT_W-1:0]               r_toCnt;
    logic [SHIFT_REG_WIDTH_MAX-1:0] r_dataOut;
    logic                           r_valid;
    logic                           r_err;

    logic w_enSync, w_enRise, w_enFall;
    logic w_sclkSync, w_sclkRise, w_sclkFall;
    logic w_sdiSync, w_sdiRise, w_sdiFall;
    logic w_timeout;
    logic w_frameGood;
    logic w_unused;

    // Enable resets high so an enable already asserted at reset release is
    // not mistaken for the start of a frame.
    sync_edge_det #(.RESET_VAL(1'b1)) u_enSync (
        .clk(clk), .rst(rst), .i_async(s2p.Serial_data_en),
        .o_sync(w_enSync), .o_rise(w_enRise), .o_fall(w_enFall)
    );

    sync_edge_det #(.RESET_VAL(1'b0)) u_sclkSync (
        .clk(clk), .rst(rst), .i_async(s2p.Serial_clk),
        .o_sync(w_sclkSync), .o_rise(w_sclkRise), .o_fall(w_sclkFall)
    );

    // Data uses the same depth as the clock so the sampled bit lines up with
    // the detected clock edge.
    sync_edge_det #(.RESET_VAL(1'b0)) u_sdiSync (
        .clk(clk), .rst(rst), .i_async(s2p.Serial_data),
        .o_sync(w_sdiSync), .o_rise(w_sdiRise), .o_fall(w_sdiFall)
    );

    assign w_unused = ^{w_sclkSync, w_sclkFall, w_sdiRise, w_sdiFall};

    // A stall only counts if neither a clock edge nor the end of the frame
    // arrives in the same cycle; both of those take precedence.
    assign w_timeout = (r_state == SHIFT) && !w_sclkRise && !w_enFall &&
                       (r_toCnt == TO_LAST);

    // A frame is accepted only with the exact programmed length, a legal
    // programmed length, and no bits dropped to overflow.
    assign w_frameGood = (r_bitCnt == s2p.S2P_Width) &&
                         (s2p.S2P_Width != '0) &&
                         (s2p.S2P_Width <= MAX_BITS) &&
                         !r_overflow;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_enRise) begin
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (w_enFall) begin
                    w_stateNext = CHECK;
                end else if (w_timeout) begin
                    w_stateNext = ABORT;
                end
            end
            CHECK: begin
                w_stateNext = IDLE;
            end
            ABORT: begin
                if (!w_enSync) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath: shift register, bit/timeout counters and registered result
    // pulses. Valid and error are defaulted low so each is a single cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_bitCnt   <= '0;
            r_overflow <= 1'b0;
            r_toCnt    <= '0;
            r_dataOut  <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_enRise) begin
                        r_shift    <= '0;
                        r_bitCnt   <= '0;
                        r_overflow <= 1'b0;
                        r_toCnt    <= '0;
                    end
                end
                SHIFT: begin
                    if (w_sclkRise) begin
                        r_toCnt <= '0;
                        if (r_bitCnt < MAX_BITS) begin
                            r_shift  <= {r_shift[SHIFT_REG_WIDTH_MAX-2:0], w_sdiSync};
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else if (r_toCnt != TO_LAST) begin
                        r_toCnt <= r_toCnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (w_frameGood) begin
                        r_dataOut <= r_shift;
                        r_valid   <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s2p.S2P_DATA_OUT = r_dataOut;
    assign s2p.S2P_Valid    = r_valid;
    assign s2p.S2P_Err      = r_err;
    assign s2p.S2P_BUSY     = (r_state != IDLE);

endmodule

// File: tb/tb_dac_spi_s2p_receiver.sv
// ============================================================================
// tb_dac_spi_s2p_receiver
// Directed bench for dac_spi_s2p_receiver. Expected frame outcomes go into a
// scoreboard queue as each frame is driven; a monitor pops and compares them
// whenever the receiver pulses S2P_Valid or S2P_Err.
// ============================================================================
`timescale 1ns/1ps
module tb_dac_spi_s2p_receiver;

    localparam int MAXW = 16;
    localparam int TO   = 1000;
    localparam int HALF = 60;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] data;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    exp_t  expQ[$];
    int    checkCount = 0;
    int    failCount  = 0;
    int    cycleCnt   = 0;
    int    errCycle   = 0;
    int    lastRise   = 0;
    logic [15:0] modelLast = 16'h0000;

    dac_spi_s2p_receiver_if #(.SHIFT_REG_WIDTH_MAX(MAXW)) bus ();

    dac_spi_s2p_receiver #(
        .SHIFT_REG_WIDTH_MAX(MAXW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s2p(bus.slave)
    );

    // 120 MHz system clock
    always #4.1667 clk = ~clk;

    // Free-running cycle counter used to time the stall abort
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && (bus.S2P_Valid === 1'b1 || bus.S2P_Err === 1'b1)) begin
            if (bus.S2P_Err === 1'b1) errCycle = cycleCnt;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", {30'd0, bus.S2P_Valid, bus.S2P_Err}, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("result_kind", {30'd0, bus.S2P_Valid, bus.S2P_Err}, {30'd0, e.kind});
                checkOutput("result_data", {16'd0, bus.S2P_DATA_OUT}, {16'd0, e.data});
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectGood(input logic [15:0] d);
        expQ.push_back('{kind: 2'b10, data: d});
        modelLast = d;
    endtask

    task automatic expectErr();
        expQ.push_back('{kind: 2'b01, data: modelLast});
    endtask

    // Serial bits MSB first; data changes while Serial_clk is low
    task automatic sendBits(input logic [31:0] value, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.Serial_data = value[i];
            waitCycles(HALF);
            bus.Serial_clk = 1'b1;
            lastRise = cycleCnt;
            waitCycles(HALF);
            bus.Serial_clk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] value, input int nbits);
        bus.Serial_data_en = 1'b1;
        waitCycles(HALF);
        sendBits(value, nbits);
        waitCycles(HALF);
        bus.Serial_data_en = 1'b0;
        waitCycles(HALF);
    endtask

    initial begin
        rst                = 1'b1;
        bus.Serial_clk     = 1'b0;
        bus.Serial_data    = 1'b0;
        bus.Serial_data_en = 1'b0;
        bus.S2P_Width      = 5'd16;
        waitCycles(5);
        checkOutput("reset_data",  {16'd0, bus.S2P_DATA_OUT}, 32'd0);
        checkOutput("reset_valid", {31'd0, bus.S2P_Valid}, 32'd0);
        checkOutput("reset_err",   {31'd0, bus.S2P_Err}, 32'd0);
        checkOutput("reset_busy",  {31'd0, bus.S2P_BUSY}, 32'd0);
        rst = 1'b0;
        waitCycles(10);

        // Width 16, 0xA5C3, with result latency checked against the en fall
        $display("[TB] frame 0xA5C3 width 16");
        expectGood(16'hA5C3);
        bus.Serial_data_en = 1'b1;
        waitCycles(HALF);
        checkOutput("busy_in_frame", {31'd0, bus.S2P_BUSY}, 32'd1);
        sendBits(32'hA5C3, 16);
        waitCycles(HALF);
        bus.Serial_data_en = 1'b0;
        waitCycles(3);
        checkOutput("valid_before_n3", {31'd0, bus.S2P_Valid}, 32'd0);
        waitCycles(1);
        checkOutput("valid_at_n3", {31'd0, bus.S2P_Valid}, 32'd1);
        waitCycles(1);
        checkOutput("valid_after_n3", {31'd0, bus.S2P_Valid}, 32'd0);
        waitCycles(HALF);

        // Width 8 then width 16
        $display("[TB] frames 0x5A width 8, 0x1234 width 16");
        bus.S2P_Width = 5'd8;
        expectGood(16'h005A);
        applyStimulus(32'h5A, 8);
        bus.S2P_Width = 5'd16;
        expectGood(16'h1234);
        applyStimulus(32'h1234, 16);

        // Short frame: 12 bits with width 16
        $display("[TB] short frame");
        expectErr();
        applyStimulus(32'hABC, 12);
        checkOutput("hold_after_short", {16'd0, bus.S2P_DATA_OUT}, 32'h1234);

        // Overflow: 17 bits with width 16
        $display("[TB] overflow frame");
        expectErr();
        applyStimulus(32'h15555, 17);

        // Stall after 5 bits: abort 1000 cycles after the last clock edge
        $display("[TB] stalled frame");
        expectErr();
        errCycle = 0;
        bus.Serial_data_en = 1'b1;
        waitCycles(HALF);
        sendBits(32'h16, 5);
        waitCycles(1100);
        checkOutput("timeout_delay", errCycle - lastRise, 32'd1003);
        checkOutput("busy_in_abort", {31'd0, bus.S2P_BUSY}, 32'd1);
        bus.Serial_data_en = 1'b0;
        waitCycles(6);
        checkOutput("busy_after_abort", {31'd0, bus.S2P_BUSY}, 32'd0);
        waitCycles(HALF);
        expectGood(16'hBEEF);
        applyStimulus(32'hBEEF, 16);

        // Reset after 7 bits, en held high through release
        $display("[TB] reset mid-frame");
        bus.Serial_data_en = 1'b1;
        waitCycles(HALF);
        sendBits(32'h55, 7);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_data", {16'd0, bus.S2P_DATA_OUT}, 32'd0);
        checkOutput("async_reset_busy", {31'd0, bus.S2P_BUSY}, 32'd0);
        modelLast = 16'h0000;
        waitCycles(5);
        rst = 1'b0;
        waitCycles(10);
        checkOutput("no_frame_after_reset", {31'd0, bus.S2P_BUSY}, 32'd0);
        bus.Serial_data_en = 1'b0;
        waitCycles(HALF);
        expectGood(16'h1234);
        applyStimulus(32'h1234, 16);
        checkOutput("final_data", {16'd0, bus.S2P_DATA_OUT}, 32'h1234);

        waitCycles(20);
        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
